// File: rtl/stdbus_slave_ram.sv
// Standard-bus slave: decodes Select-framed bursts from the bus master and
// reads/writes an internal 16-bit word RAM, with a registered local read port.
module stdbus_slave_ram #(
    parameter int MemDepth = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Select,
    input  logic        Direct_In,
    input  logic [8:0]  AddrBus_In,
    input  logic [15:0] DataBus_In,
    input  logic        DataBusStrobe,
    output logic [15:0] DataBusOut,
    output logic        DataBusStrobeOut,
    output logic        Error,
    input  logic [8:0]  UserAddr,
    output logic [15:0] UserData,
    output logic [2:0]  dbg_state
);

    localparam int         AW    = (MemDepth > 1) ? $clog2(MemDepth) : 1;
    localparam logic [9:0] DEPTH = 10'(MemDepth);

    // Handshake: a word moves on every cycle where Select and DataBusStrobe are
    // both high; DataBusStrobeOut is high for exactly one cycle per read word.
    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        IDLE  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [8:0]  ptr, ptr_nxt;
    logic        dir, dir_nxt;
    logic        xfer, xfer_wr, err_set, err_clr;
    logic [8:0]  xfer_addr;
    logic        in_range, user_in_range;
    logic        we, re;

    logic [15:0] mem [MemDepth];

    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        dir_nxt   = dir;
        xfer      = 1'b0;
        xfer_wr   = dir;
        xfer_addr = ptr;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        case (state)
            SYNC: begin
                if (!Select) state_nxt = IDLE;
            end
            IDLE: begin
                if (Select) begin
                    // The burst-start cycle may already carry the first word.
                    dir_nxt   = Direct_In;
                    ptr_nxt   = AddrBus_In;
                    err_clr   = 1'b1;
                    xfer_addr = AddrBus_In;
                    xfer_wr   = Direct_In;
                    xfer      = DataBusStrobe;
                    state_nxt = Direct_In ? WRITE : READ;
                end
            end
            WRITE, READ: begin
                if (!Select) begin
                    state_nxt = IDLE;
                end else if (Direct_In != dir) begin
                    err_set   = 1'b1;
                    state_nxt = ABORT;
                end else begin
                    xfer = DataBusStrobe;
                end
            end
            ABORT: begin
                if (!Select) state_nxt = IDLE;
            end
            default: state_nxt = SYNC;
        endcase

        in_range = ({1'b0, xfer_addr} < DEPTH);
        if (xfer) begin
            ptr_nxt = xfer_addr + 9'd1;
            if (!in_range) err_set = 1'b1;
        end
    end

    assign we            = xfer && xfer_wr && in_range;
    assign re            = xfer && !xfer_wr;
    assign user_in_range = ({1'b0, UserAddr} < DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= SYNC;
            ptr              <= 9'd0;
            dir              <= 1'b0;
            Error            <= 1'b0;
            DataBusOut       <= 16'h0000;
            DataBusStrobeOut <= 1'b0;
            UserData         <= 16'h0000;
        end else begin
            state            <= state_nxt;
            ptr              <= ptr_nxt;
            dir              <= dir_nxt;
            DataBusStrobeOut <= re;
            if (err_set)      Error <= 1'b1;
            else if (err_clr) Error <= 1'b0;
            if (re) DataBusOut <= in_range ? mem[xfer_addr[AW-1:0]] : 16'h0000;
            // Non-blocking read gives read-before-write against a same-cycle bus write.
            UserData <= user_in_range ? mem[UserAddr[AW-1:0]] : 16'h0000;
        end
    end

    // RAM has no reset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (we) mem[xfer_addr[AW-1:0]] <= DataBus_In;
    end

endmodule

// File: tb/tb_stdbus_slave_ram.sv
// Directed bench for stdbus_slave_ram: a full-depth instance and a 256-word
// instance share all inputs so range behaviour can be checked alongside.
module tb_stdbus_slave_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel, dir, stb;
  logic [8:0]  abus, uaddr;
  logic [15:0] dbus;

  logic [15:0] dbo0, ud0, dbo1, ud1;
  logic        sbo0, err0, sbo1, err1;
  logic [2:0]  st0, st1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  localparam logic [2:0] S_SYNC = 3'd0, S_IDLE = 3'd1, S_ABORT = 3'd4;

  stdbus_slave_ram #(.MemDepth(512)) dut0 (
    .clk(clk), .rst(rst), .Select(sel), .Direct_In(dir), .AddrBus_In(abus),
    .DataBus_In(dbus), .DataBusStrobe(stb), .DataBusOut(dbo0),
    .DataBusStrobeOut(sbo0), .Error(err0), .UserAddr(uaddr), .UserData(ud0),
    .dbg_state(st0)
  );

  stdbus_slave_ram #(.MemDepth(256)) dut1 (
    .clk(clk), .rst(rst), .Select(sel), .Direct_In(dir), .AddrBus_In(abus),
    .DataBus_In(dbus), .DataBusStrobe(stb), .DataBusOut(dbo1),
    .DataBusStrobeOut(sbo1), .Error(err1), .UserAddr(uaddr), .UserData(ud1),
    .dbg_state(st1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_burst(input logic [8:0] a, input logic [15:0] d0, input int n);
    sel = 1'b1; dir = 1'b1; abus = a;
    for (int i = 0; i < n; i++) begin
      stb = 1'b1; dbus = d0 + 16'(i);
      tick();
    end
    stb = 1'b0; sel = 1'b0;
    tick();
  endtask

  task automatic peek(input string tag, input logic [8:0] a, input logic [15:0] exp);
    uaddr = a;
    tick();
    check(tag, ud0, exp);
  endtask

  task automatic rd_step(input logic s);
    stb = s;
    tick();
    check("rd_sbo", {15'd0, sbo0}, {15'd0, s});
    if (sbo0) begin
      if (exp_q.size() > 0) check("rd_data", dbo0, exp_q.pop_front());
      else check("rd_extra", {15'd0, sbo0}, 16'd0);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; dir = 1'b0; stb = 1'b0;
    abus = 9'd0; uaddr = 9'd0; dbus = 16'd0;
    tick(); tick();
    check("rst_dbo", dbo0, 16'h0000);
    check("rst_sbo", {15'd0, sbo0}, 16'd0);
    check("rst_err", {15'd0, err0}, 16'd0);
    check("rst_ud",  ud0, 16'h0000);
    check("rst_state", {13'd0, st0}, {13'd0, S_SYNC});
    rst = 1'b0;
    tick();
    check("sync_to_idle", {13'd0, st0}, {13'd0, S_IDLE});

    // Write burst of four words
    wr_burst(9'h010, 16'hA000, 4);
    check("wr_err", {15'd0, err0}, 16'd0);
    peek("wr_ud12", 9'h012, 16'hA002);
    peek("wr_ud10", 9'h010, 16'hA000);
    peek("wr_ud13", 9'h013, 16'hA003);

    // Read burst with a one-cycle gap after the first strobe
    for (int i = 0; i < 4; i++) exp_q.push_back(16'hA000 + 16'(i));
    sel = 1'b1; dir = 1'b0; abus = 9'h010;
    rd_step(1'b1);
    rd_step(1'b0);
    check("rd_hold", dbo0, 16'hA000);
    rd_step(1'b1);
    rd_step(1'b1);
    rd_step(1'b1);
    sel = 1'b0;
    rd_step(1'b0);
    check("rd_q_empty", 16'(exp_q.size()), 16'd0);
    check("rd_err", {15'd0, err0}, 16'd0);

    // Address wrap at 0x1FF
    wr_burst(9'h1FF, 16'hB000, 3);
    check("wrap_err512", {15'd0, err0}, 16'd0);
    check("wrap_err256", {15'd0, err1}, 16'd1);
    peek("wrap_1ff", 9'h1FF, 16'hB000);
    peek("wrap_000", 9'h000, 16'hB001);
    peek("wrap_001", 9'h001, 16'hB002);

    // Out-of-range read on the 256-word instance
    wr_burst(9'h0FF, 16'hC0FF, 1);
    sel = 1'b1; dir = 1'b0; abus = 9'h0FF; stb = 1'b1;
    tick();
    check("rng_d0", dbo1, 16'hC0FF);
    check("rng_err0", {15'd0, err1}, 16'd0);
    tick();
    check("rng_d1", dbo1, 16'h0000);
    check("rng_sbo1", {15'd0, sbo1}, 16'd1);
    check("rng_err1", {15'd0, err1}, 16'd1);
    check("rng_err512", {15'd0, err0}, 16'd0);
    sel = 1'b0; stb = 1'b0;
    tick();
    check("rng_err_sticky", {15'd0, err1}, 16'd1);

    // Direction violation on the second strobe
    wr_burst(9'h030, 16'h1110, 3);
    sel = 1'b1; dir = 1'b1; abus = 9'h030; stb = 1'b1; dbus = 16'hD000;
    tick();
    dir = 1'b0; dbus = 16'hD001;
    tick();
    check("dir_err", {15'd0, err0}, 16'd1);
    check("dir_abort", {13'd0, st0}, {13'd0, S_ABORT});
    dbus = 16'hD002;
    tick();
    check("dir_no_sbo", {15'd0, sbo0}, 16'd0);
    dir = 1'b1; dbus = 16'hD003;
    tick();
    sel = 1'b0; stb = 1'b0;
    tick();
    check("dir_err_hold", {15'd0, err0}, 16'd1);
    peek("dir_m30", 9'h030, 16'hD000);
    peek("dir_m31", 9'h031, 16'h1111);
    peek("dir_m32", 9'h032, 16'h1112);
    sel = 1'b1; dir = 1'b1; abus = 9'h040;
    tick();
    check("dir_err_clr", {15'd0, err0}, 16'd0);
    sel = 1'b0;
    tick();

    // Reset in the middle of a write burst
    wr_burst(9'h050, 16'h2222, 1);
    uaddr = 9'h050;
    sel = 1'b1; dir = 1'b0; abus = 9'h050; stb = 1'b1;
    tick();
    check("pre_rst_rd", dbo0, 16'h2222);
    sel = 1'b0; stb = 1'b0;
    tick();
    check("pre_rst_ud", ud0, 16'h2222);
    sel = 1'b1; dir = 1'b1; abus = 9'h050;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_dbo", dbo0, 16'h0000);
    check("mid_rst_ud", ud0, 16'h0000);
    check("mid_rst_state", {13'd0, st0}, {13'd0, S_SYNC});
    tick();
    rst = 1'b0;
    stb = 1'b1; dbus = 16'h4444;
    tick();
    check("post_rst_state", {13'd0, st0}, {13'd0, S_SYNC});
    tick();
    check("post_rst_sbo", {15'd0, sbo0}, 16'd0);
    check("post_rst_err", {15'd0, err0}, 16'd0);
    sel = 1'b0; stb = 1'b0;
    tick();
    check("post_rst_idle", {13'd0, st0}, {13'd0, S_IDLE});
    check("post_rst_mem", ud0, 16'h2222);
    sel = 1'b1; dir = 1'b0; abus = 9'h050; stb = 1'b1;
    tick();
    check("resume_sbo", {15'd0, sbo0}, 16'd1);
    check("resume_rd", dbo0, 16'h2222);
    sel = 1'b0; stb = 1'b0;
    tick();

    // Write-then-read hazard and same-cycle read-before-write
    wr_burst(9'h020, 16'h0BAD, 1);
    uaddr = 9'h020;
    sel = 1'b1; dir = 1'b1; abus = 9'h020; stb = 1'b1; dbus = 16'h5555;
    tick();
    check("rbw_old", ud0, 16'h0BAD);
    sel = 1'b0; stb = 1'b0;
    tick();
    check("raw_new", ud0, 16'h5555);
    sel = 1'b1; dir = 1'b0; abus = 9'h020; stb = 1'b1;
    tick();
    check("raw_bus", dbo0, 16'h5555);
    sel = 1'b0; stb = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stdbus_slave_ram.md
# stdbus_slave_ram

Standard-bus slave responder: the target end of the master transactions issued by the USB bridge (AccessRequest/AddrBusOut/DirectOut/DataBusStrobe). Decodes Select/Direct_In/AddrBus_In bursts, auto-increments the word address, and writes to or reads from an internal 16-bit word RAM. Returns read data with a registered strobe and flags protocol or range violations on Error. A second read-only port exposes the RAM contents to local logic (configuration registers).

## Interface
- MemDepth, 512: number of 16-bit words implemented (1..512); addresses >= MemDepth are out of range.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Select  in  1  transaction frame; high for the whole burst.
- Direct_In  in  1  1 = master writes to slave, 0 = master reads from slave; sampled at burst start.
- AddrBus_In  in  9  start word address; sampled at burst start.
- DataBus_In  in  16  write data, valid with DataBusStrobe.
- DataBusStrobe  in  1  one word transferred per cycle it is high.
- DataBusOut  out  16  read data, registered.
- DataBusStrobeOut  out  1  read data valid, one cycle per returned word.
- Error  out  1  sticky violation flag for the current burst.
- UserAddr  in  9  local read address.
- UserData  out  16  mem[UserAddr], one-cycle registered latency; 0 if out of range.

## Operation
- States: SYNC, IDLE, WRITE, READ, ABORT.
- SYNC (reset state): wait for Select=0, then IDLE. Prevents joining a burst already in progress at reset release.
- IDLE: on Select=1, latch ptr <= AddrBus_In and dir <= Direct_In, clear Error; go to WRITE (dir=1) or READ (dir=0). A strobe in this same cycle is processed as the first word, at AddrBus_In.
- WRITE: each cycle with Select=1 and DataBusStrobe=1: if ptr < MemDepth, mem[ptr] <= DataBus_In, else the word is dropped and Error <= 1; ptr <= ptr+1.
- READ: each strobe cycle: DataBusOut <= (ptr < MemDepth) ? mem[ptr] : 16'h0000, DataBusStrobeOut <= 1; if out of range, Error <= 1; ptr <= ptr+1.
- ptr is 9 bits, wraps 511 -> 0 with no error. With MemDepth < 512, the out-of-range window lies between MemDepth-1 and the wrap.
- If Direct_In differs from latched dir while Select=1: Error <= 1, go to ABORT. The offending cycle's strobe is ignored.
- ABORT: all strobes ignored, no RAM writes, no DataBusStrobeOut; Select=0 -> IDLE.
- WRITE/READ: Select=0 -> IDLE. A strobe with Select=0 is ignored and does not set Error.
- Error stays high after the burst ends until the next burst start or reset.
- RAM contents are not reset; power-up values are undefined.

## Timing
- Reset values: DataBusOut=0, DataBusStrobeOut=0, Error=0, UserData=0, ptr=0, state=SYNC.
- Write latency: a strobe in cycle N updates RAM at the edge ending N. A bus read or UserAddr read of the same word issued in N+1 returns the new data.
- Read latency: a strobe in cycle N gives DataBusOut/DataBusStrobeOut valid in N+1 (1 cycle). Back-to-back strobes give back-to-back valid words. DataBusOut holds its last value when the strobe is low.
- Select falling in the cycle after the last read strobe still delivers that word's DataBusStrobeOut.
- Simultaneous bus write and UserAddr read of the same address in one cycle: UserData returns the old value (read-before-write).
- Error asserts in the cycle after the violating input is sampled.
- rst asserted mid-burst: outputs clear immediately (async). After release, the block sits in SYNC until Select=0; no transfers occur in that burst.

## Test plan
- Write burst: Select=1, Direct_In=1, AddrBus_In=0x010, 4 strobes with data 0xA000..0xA003 -> mem[0x10..0x13] hold those values; Error=0; UserAddr=0x012 gives UserData=0xA002 one cycle later.
- Read burst: read 4 words from 0x010 with strobes on cycles N, N+2, N+3, N+4 -> DataBusStrobeOut on N+1, N+3, N+4, N+5 with 0xA000..0xA003 in order.
- Wrap and range: MemDepth=512, write 3 words at 0x1FF -> words land at 0x1FF, 0x000, 0x001, Error=0. MemDepth=256, read 2 words at 0x0FF -> mem[0xFF] then 0x0000, Error=1 after the second strobe, and Error still 1 after Select falls.
- Direction violation: write burst, Direct_In toggles to 0 on the 2nd strobe -> only the 1st word is written, Error=1, no further writes or read strobes until Select=0. A new burst then clears Error.
- Reset mid-burst: assert rst during a write burst with Select held high, release, continue strobing -> no RAM change and all outputs 0. After Select=0 and a new burst, normal operation resumes.
- Write-then-read hazard: write 0x5555 to 0x020 in cycle N, read 0x020 via a new burst or UserAddr in N+1 -> returns 0x5555. Same-cycle UserAddr=0x020 in N -> returns the prior value.
